// File: rtl/cla_pkg.sv
// Shared sizing constants for the 16-bit carry-lookahead adder and its
// lookahead carry units.
package cla_pkg;

    localparam int GROUP_W  = 4;
    localparam int N_GROUPS = 4;

endpackage

// File: rtl/cla16_lcu.sv
// lcu: 4-bit lookahead carry unit. Purely combinational, usable both at bit
// level and for cascading group propagate/generate pairs.
module lcu
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               cIn,
    output logic               pg,
    output logic               gg,
    output logic               cOut,
    output logic [GROUP_W-1:1] c
);

    // Every carry is a flat sum of products; none waits on another carry.
    assign c[1] = g[0] | (p[0] & cIn);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cIn);

    assign pg   = p[3] & p[2] & p[1] & p[0];
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign cOut = gg | (pg & cIn);

endmodule

// File: rtl/cla16.sv
// cla16: 16-bit two-level carry-lookahead adder (four group lcus plus one
// top lcu). Define CLA16_OUT_REG_EN to register s/cOut/pg/gg on clk.
module cla16
    import cla_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cIn,
    output logic [15:0] s,
    output logic        cOut,
    output logic        pg,
    output logic        gg
);

    logic [15:0]         p;
    logic [15:0]         g;
    logic [15:0]         c;
    logic [15:0]         sum_c;
    logic [N_GROUPS-1:0] grp_p;
    logic [N_GROUPS-1:0] grp_g;
    logic [N_GROUPS-1:0] grp_cin;
    logic [N_GROUPS-1:0] grp_cout_unused;
    logic                cout_c;
    logic                pg_c;
    logic                gg_c;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_grp
        lcu u_lcu (
            .p    (p[gi*GROUP_W +: GROUP_W]),
            .g    (g[gi*GROUP_W +: GROUP_W]),
            .cIn  (grp_cin[gi]),
            .pg   (grp_p[gi]),
            .gg   (grp_g[gi]),
            .cOut (grp_cout_unused[gi]),
            .c    (c[gi*GROUP_W+1 +: GROUP_W-1])
        );
        assign c[gi*GROUP_W] = grp_cin[gi];
    end

    // Group carry-ins come from the second level, never from a neighbour group.
    assign grp_cin[0] = cIn;

    lcu u_lcu_top (
        .p    (grp_p),
        .g    (grp_g),
        .cIn  (cIn),
        .pg   (pg_c),
        .gg   (gg_c),
        .cOut (cout_c),
        .c    (grp_cin[N_GROUPS-1:1])
    );

    assign sum_c = p ^ c;

`ifdef CLA16_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s    <= '0;
            cOut <= 1'b0;
            pg   <= 1'b0;
            gg   <= 1'b0;
        end else begin
            s    <= sum_c;
            cOut <= cout_c;
            pg   <= pg_c;
            gg   <= gg_c;
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;

    assign s    = sum_c;
    assign cOut = cout_c;
    assign pg   = pg_c;
    assign gg   = gg_c;
`endif

endmodule

// File: tb/tb_cla16.sv
// Scoreboard bench for cla16; handles both the combinational build and the
// CLA16_OUT_REG_EN registered build.
module tb_cla16;

`ifdef CLA16_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        pg;
        logic        gg;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        pg;
        logic        gg;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cIn = 1'b0;
    logic [15:0] s;
    logic        cOut;
    logic        pg;
    logic        gg;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    cla16 dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .cIn   (cIn),
        .s     (s),
        .cOut  (cOut),
        .pg    (pg),
        .gg    (gg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare whatever result is due on this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (s !== e.s || cOut !== e.co || pg !== e.pg || gg !== e.gg) begin
                failures++;
                $display("FAIL %s: got s=%h cOut=%b pg=%b gg=%b, want s=%h cOut=%b pg=%b gg=%b",
                         e.name, s, cOut, pg, gg, e.s, e.co, e.pg, e.gg);
            end
        end
    end

    task automatic push_exp(input logic [15:0] es, input logic eco, input logic epg,
                            input logic egg, input string name);
        exp_t e;
        e.s = es; e.co = eco; e.pg = epg; e.gg = egg;
        e.due = cyc + LAT;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vrst);
        @(posedge clk);
        #1;
        a = va; b = vb; cIn = vc; reset = vrst;
    endtask

    // Reference from plain integer addition; gg is the carry of a+b alone.
    task automatic issue_model(input logic [15:0] va, input logic [15:0] vb,
                               input logic vc, input string name);
        logic [16:0] full;
        logic [16:0] gen;
        drive(va, vb, vc, 1'b0);
        full = {1'b0, va} + {1'b0, vb} + {16'b0, vc};
        gen  = {1'b0, va} + {1'b0, vb};
        push_exp(full[15:0], full[16], &(va ^ vb), gen[16], name);
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] corners[4];
        logic [15:0] ra;
        logic [15:0] rb;
        corners[0] = 16'h0000; corners[1] = 16'hFFFF;
        corners[2] = 16'h8000; corners[3] = 16'h7FFF;

        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "one_plus_one"});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "full_carry"});
        vecs.push_back('{16'hCCCC, 16'h3333, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, "all_prop_cin0"});
        vecs.push_back('{16'hCCCC, 16'h3333, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, "all_prop_cin1"});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, "max_plus_max"});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, "cin_only"});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "msb_generate"});
        vecs.push_back('{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, "prop_ripple_cin"});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "no_carry_mix"});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "cross_groups"});

        // Reset state, then a+b held through reset and released.
        drive(16'h0000, 16'h0000, 1'b0, 1'b1);
        if (LAT == 1) push_exp(16'h0000, 1'b0, 1'b0, 1'b0, "reset_state");
        else          push_exp(16'h0000, 1'b0, 1'b0, 1'b0, "comb_zero_sum");
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        if (LAT == 1) push_exp(16'h0000, 1'b0, 1'b0, 1'b0, "during_reset");
        else          push_exp(16'h8000, 1'b0, 1'b0, 1'b0, "reset_ignored");
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        push_exp(16'h8000, 1'b0, 1'b0, 1'b0, "after_reset");

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            push_exp(vecs[i].s, vecs[i].co, vecs[i].pg, vecs[i].gg, vecs[i].name);
        end

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 2; k++)
                    issue_model(corners[i], corners[j], k[0], "corner");

        for (int n = 0; n < 10000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = corners[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) rb = corners[$urandom_range(0, 3)];
            issue_model(ra, rb, 1'($urandom), "random");
        end

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d results still pending, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla16.md
CLA16 -- requirements
Module: cla16

Interface
REQ-001 Parameters: none; width fixed at 16 bits, organised as 4 groups of 4 bits.
REQ-002 clk  input  1  rising-edge clock; used only when CLA16_OUT_REG_EN is defined.
REQ-003 reset  input  1  synchronous, active-high reset; used only when CLA16_OUT_REG_EN is defined.
REQ-004 a  input  16  addend A.
REQ-005 b  input  16  addend B.
REQ-006 cIn  input  1  carry into bit 0.
REQ-007 s  output  16  sum bits, (a + b + cIn) mod 2^16.
REQ-008 cOut  output  1  carry out of bit 15.
REQ-009 pg  output  1  group propagate of the whole 16-bit block.
REQ-010 gg  output  1  group generate of the whole 16-bit block.

Function
REQ-011 Bit level SHALL use p[i] = a[i] XOR b[i] and g[i] = a[i] AND b[i], with s[i] = p[i] XOR c[i] and c[0] = cIn.
REQ-012 Each 4-bit group SHALL produce its internal carries, group pg and group gg through one lcu instance fed with that group's p/g and group carry-in.
REQ-013 A second-level lcu SHALL take the four group pg/gg values plus cIn and SHALL produce the group carry-ins c4, c8 and c12, plus cOut, pg and gg.
REQ-014 lcu equations:
- c1 = g0 | p0·cin
- c2 = g1 | p1·g0 | p1·p0·cin
- c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·cin
- pg = p3·p2·p1·p0
- gg = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
- cOut = gg | pg·cin
REQ-015 Carries SHALL be computed in lookahead form only; no ripple chain longer than within one lcu equation.
REQ-016 pg and gg SHALL be independent of cIn.
REQ-017 cOut SHALL equal bit 16 of the 17-bit sum a + b + cIn, for every input combination.
REQ-018 pg and gg SHALL be valid for cascading; a parent lcu may ignore cOut and rely on pg and gg alone.

Reset
REQ-019 With CLA16_OUT_REG_EN defined, reset high at a rising clk edge SHALL clear s, cOut, pg and gg to 0 on that edge.
REQ-020 Reset SHALL dominate input updates; an operation in flight during reset SHALL be discarded.
REQ-021 The first valid result after reset SHALL appear on the edge after reset deasserts.
REQ-022 Without CLA16_OUT_REG_EN, the block SHALL hold no state, and reset and clk SHALL have no effect.

Configuration
REQ-023 Macro CLA16_OUT_REG_EN defined: s, cOut, pg and gg SHALL be registered on rising clk, giving latency 1 cycle and throughput 1 result per cycle.
REQ-024 Macro CLA16_OUT_REG_EN undefined: all outputs SHALL be purely combinational with latency 0, and the port list SHALL be unchanged.

Structure
REQ-025 Shared package cla_pkg SHALL hold GROUP_W=4 and N_GROUPS=4.
REQ-026 Sub-module lcu (4-bit lookahead carry unit) SHALL be separate and reusable, with ports:
- outputs: pg, gg, cOut, c[3:1]
- inputs: p[3:0], g[3:0], cIn
REQ-027 cla16 SHALL instantiate lcu five times: four group instances and one top-level instance.
REQ-028 lcu SHALL be purely combinational in both configurations.

Verification (outputs are sampled after 1 clk edge when CLA16_OUT_REG_EN is defined)
REQ-029 a=0x0001, b=0x0001, cIn=0 -> s=0x0002, cOut=0, pg=0, gg=0.
REQ-030 a=0xFFFF, b=0x0001, cIn=0 -> s=0x0000, cOut=1, pg=0, gg=1 (full carry through).
REQ-031 a=0xCCCC, b=0x3333:
- cIn=0 -> s=0xFFFF, cOut=0, pg=1, gg=0
- cIn=1 -> s=0x0000, cOut=1, pg=1, gg=0
REQ-032 a=0xFFFF, b=0xFFFF, cIn=1 -> s=0xFFFF, cOut=1, pg=0, gg=1.
REQ-033 Reset check (CLA16_OUT_REG_EN defined): apply a=0x7FFF, b=0x0001 and hold reset high for one edge.
- During reset -> all outputs 0.
- Next edge after reset deasserts -> s=0x8000, cOut=0.
REQ-034 Random and exhaustive-corner sweep: {s, cOut} SHALL equal a + b + cIn for at least 10000 random vectors, including 0x0000, 0xFFFF, 0x8000 and 0x7FFF operands.
